// File: rtl/throw_encoder_pkg.sv
// Shared types and constants for the rock-paper-scissors throw encoder.
// Button vectors are ordered {paper, scissors, rock}.
package throw_encoder_pkg;

    typedef enum logic [1:0] {
        MV_R = 2'd0,
        MV_S = 2'd1,
        MV_P = 2'd2
    } move_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_COLLECT,
        ST_ISSUE,
        ST_RELEASE
    } state_t;

    localparam logic [3:0] KEY_RR   = 4'd0;
    localparam logic [3:0] KEY_SS   = 4'd1;
    localparam logic [3:0] KEY_RS   = 4'd2;
    localparam logic [3:0] KEY_RP   = 4'd3;
    localparam logic [3:0] KEY_SR   = 4'd4;
    localparam logic [3:0] KEY_PP   = 4'd5;
    localparam logic [3:0] KEY_SP   = 4'd6;
    localparam logic [3:0] KEY_PR   = 4'd7;
    localparam logic [3:0] KEY_PS   = 4'd8;
    localparam logic [3:0] KEY_IDLE = 4'hF;

    // Only called with a one-hot vector; anything else falls back to rock.
    function automatic move_t btn_move(input logic [2:0] btn);
        case (btn)
            3'b010:  return MV_S;
            3'b100:  return MV_P;
            default: return MV_R;
        endcase
    endfunction

    function automatic logic [3:0] key_code(input move_t a, input move_t b);
        case ({a, b})
            {MV_R, MV_R}: return KEY_RR;
            {MV_S, MV_S}: return KEY_SS;
            {MV_P, MV_P}: return KEY_PP;
            {MV_R, MV_S}: return KEY_RS;
            {MV_S, MV_P}: return KEY_SP;
            {MV_P, MV_R}: return KEY_PR;
            {MV_R, MV_P}: return KEY_RP;
            {MV_S, MV_R}: return KEY_SR;
            {MV_P, MV_S}: return KEY_PS;
            default:      return KEY_IDLE;
        endcase
    endfunction

endpackage

// File: rtl/throw_encoder_debounce.sv
// Single-button conditioner: two-flop synchronizer feeding a saturating
// stability counter. Any low sample after the synchronizer clears the count.
module btn_debounce #(
    parameter int DEB_CYC = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic btn,
    output logic pressed,
    output logic released
);
    localparam int CW = $clog2(DEB_CYC + 1);

    logic [1:0]    sync_reg;
    logic [CW-1:0] cnt_reg;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync_reg <= '0;
            cnt_reg  <= '0;
        end else begin
            sync_reg <= {sync_reg[0], btn};
            if (!sync_reg[1]) begin
                cnt_reg <= '0;
            end else if (cnt_reg != CW'(DEB_CYC)) begin
                cnt_reg <= cnt_reg + CW'(1);
            end
        end
    end

    assign pressed  = (cnt_reg == CW'(DEB_CYC));
    assign released = (cnt_reg == '0);

endmodule

// File: rtl/throw_encoder.sv
// Collects one debounced throw from each player, then emits a single-cycle
// round code for the scorer and waits for all buttons to be let go.
module throw_encoder
    import throw_encoder_pkg::*;
#(
    parameter int DEB_CYC = 16,
    parameter int TMO_CYC = 1000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [2:0] a_btn,
    input  logic [2:0] b_btn,
    input  logic [1:0] player,
    output logic [3:0] key,
    output logic       start,
    output logic       a_lock,
    output logic       b_lock
);
    localparam int TW = $clog2(TMO_CYC + 1);
    localparam int RW = $clog2(DEB_CYC + 1);

    logic [5:0] raw;
    logic [5:0] pressed;
    logic [5:0] released;

    assign raw = {b_btn, a_btn};

    generate
        for (genvar gi = 0; gi < 6; gi++) begin : g_deb
            btn_debounce #(.DEB_CYC(DEB_CYC)) u_deb (
                .clk      (clk),
                .rst      (rst),
                .btn      (raw[gi]),
                .pressed  (pressed[gi]),
                .released (released[gi])
            );
        end
    endgenerate

    logic a_valid, b_valid, all_released;
    assign a_valid      = $onehot(pressed[2:0]);
    assign b_valid      = $onehot(pressed[5:3]);
    assign all_released = &released;

    state_t        state_reg, state_next;
    move_t         a_move_reg, a_move_next, b_move_reg, b_move_next;
    logic          a_lock_reg, a_lock_next, b_lock_reg, b_lock_next;
    logic [TW-1:0] tmo_reg, tmo_next;
    logic [RW-1:0] rel_reg, rel_next;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg  <= ST_IDLE;
            a_move_reg <= MV_R;
            b_move_reg <= MV_R;
            a_lock_reg <= 1'b0;
            b_lock_reg <= 1'b0;
            tmo_reg    <= '0;
            rel_reg    <= '0;
        end else begin
            state_reg  <= state_next;
            a_move_reg <= a_move_next;
            b_move_reg <= b_move_next;
            a_lock_reg <= a_lock_next;
            b_lock_reg <= b_lock_next;
            tmo_reg    <= tmo_next;
            rel_reg    <= rel_next;
        end
    end

    always_comb begin
        state_next  = state_reg;
        a_move_next = a_move_reg;
        b_move_next = b_move_reg;
        a_lock_next = a_lock_reg;
        b_lock_next = b_lock_reg;
        tmo_next    = '0;
        rel_next    = '0;
        case (state_reg)
            ST_IDLE: begin
                if (player == 2'b00) begin
                    if (a_valid) begin
                        a_lock_next = 1'b1;
                        a_move_next = btn_move(pressed[2:0]);
                    end
                    if (b_valid) begin
                        b_lock_next = 1'b1;
                        b_move_next = btn_move(pressed[5:3]);
                    end
                    if (a_valid && b_valid) begin
                        state_next = ST_ISSUE;
                    end else if (a_valid || b_valid) begin
                        state_next = ST_COLLECT;
                    end
                end
            end
            ST_COLLECT: begin
                if (player != 2'b00) begin
                    a_lock_next = 1'b0;
                    b_lock_next = 1'b0;
                    state_next  = ST_IDLE;
                end else if (!a_lock_reg && a_valid) begin
                    a_lock_next = 1'b1;
                    a_move_next = btn_move(pressed[2:0]);
                    state_next  = ST_ISSUE;
                end else if (!b_lock_reg && b_valid) begin
                    b_lock_next = 1'b1;
                    b_move_next = btn_move(pressed[5:3]);
                    state_next  = ST_ISSUE;
                end else if (tmo_reg >= TW'(TMO_CYC - 1)) begin
                    a_lock_next = 1'b0;
                    b_lock_next = 1'b0;
                    state_next  = ST_IDLE;
                end else begin
                    tmo_next = tmo_reg + TW'(1);
                end
            end
            ST_ISSUE: begin
                state_next = ST_RELEASE;
            end
            ST_RELEASE: begin
                // Leave only after DEB_CYC consecutive all-released cycles.
                if (all_released) begin
                    if (rel_reg >= RW'(DEB_CYC - 1)) begin
                        a_lock_next = 1'b0;
                        b_lock_next = 1'b0;
                        state_next  = ST_IDLE;
                    end else begin
                        rel_next = rel_reg + RW'(1);
                    end
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        start  = (state_reg == ST_ISSUE);
        key    = start ? key_code(a_move_reg, b_move_reg) : KEY_IDLE;
        a_lock = a_lock_reg;
        b_lock = b_lock_reg;
    end

endmodule

// File: tb/tb_throw_encoder.sv
// Directed bench for throw_encoder: lock/issue/release rounds, invalid
// multi-press, glitch rejection, timeout, match-over abort and mid-round reset.
module tb_throw_encoder;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [2:0] a_btn = 3'b000;
    logic [2:0] b_btn = 3'b000;
    logic [1:0] player = 2'b00;
    logic [3:0] key;
    logic       start;
    logic       a_lock;
    logic       b_lock;

    int checks = 0;
    int failures = 0;
    int start_cnt = 0;
    int key_bad = 0;
    logic [3:0] last_key = 4'hE;
    int base;
    bit found;

    localparam logic [2:0] R = 3'b001;
    localparam logic [2:0] S = 3'b010;
    localparam logic [2:0] P = 3'b100;

    logic [2:0] a_tab [9] = '{R, S, R, R, S, P, S, P, P};
    logic [2:0] b_tab [9] = '{R, S, S, P, R, P, P, R, S};
    logic [3:0] k_tab [9] = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd8};

    throw_encoder #(.DEB_CYC(16), .TMO_CYC(100)) dut (
        .clk    (clk),
        .rst    (rst),
        .a_btn  (a_btn),
        .b_btn  (b_btn),
        .player (player),
        .key    (key),
        .start  (start),
        .a_lock (a_lock),
        .b_lock (b_lock)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (start === 1'b1) begin
            start_cnt++;
            last_key = key;
        end else if (key !== 4'hF) begin
            key_bad++;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        // Reset state
        #2 rst = 1'b0;
        #1;
        chk("reset_key", key, 4'hF);
        chk("reset_start", start, 1'b0);
        chk("reset_locks", {a_lock, b_lock}, 2'b00);
        tick(3);
        rst = 1'b1;
        tick(3);
        chk("idle_key", key, 4'hF);

        // A rock, B scissors 50 cycles later -> key 2
        a_btn = R;
        tick(50);
        chk("s1_a_locked", {a_lock, b_lock}, 2'b10);
        chk("s1_no_start_yet", start_cnt, 0);
        b_btn = S;
        tick(25);
        chk("s1_start_once", start_cnt, 1);
        chk("s1_key", last_key, 4'd2);
        chk("s1_key_after", key, 4'hF);
        chk("s1_locks_held", {a_lock, b_lock}, 2'b11);
        a_btn = 3'b000; b_btn = 3'b000;
        tick(40);
        chk("s1_locks_cleared", {a_lock, b_lock}, 2'b00);

        // Both paper same cycle -> both lock together and ISSUE directly
        base = start_cnt;
        a_btn = P; b_btn = P;
        found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            tick(1);
            if (a_lock || b_lock) found = 1'b1;
        end
        chk("s2_locks_together", {a_lock, b_lock}, 2'b11);
        chk("s2_start_same_cycle", start, 1'b1);
        chk("s2_key", key, 4'd5);
        tick(1);
        chk("s2_start_pulse_end", start, 1'b0);
        chk("s2_key_idle", key, 4'hF);
        a_btn = 3'b000; b_btn = 3'b000;
        tick(40);
        chk("s2_start_count", start_cnt - base, 1);
        chk("s2_locks_cleared", {a_lock, b_lock}, 2'b00);

        // A rock+paper (invalid), B rock -> only B locks, then timeout
        base = start_cnt;
        a_btn = R | P; b_btn = R;
        tick(30);
        chk("s3_only_b", {a_lock, b_lock}, 2'b01);
        b_btn = 3'b000;
        tick(80);
        chk("s3_still_collect", {a_lock, b_lock}, 2'b01);
        tick(20);
        chk("s3_timeout_clear", {a_lock, b_lock}, 2'b00);
        chk("s3_no_start", start_cnt - base, 0);
        a_btn = 3'b000;
        tick(10);

        // 10-cycle glitch is rejected
        a_btn = R;
        tick(10);
        a_btn = 3'b000;
        tick(30);
        chk("s4_glitch_no_lock", {a_lock, b_lock}, 2'b00);

        // Hold through a round; no new start until all released for 16 cycles
        base = start_cnt;
        a_btn = R; b_btn = P;
        tick(40);
        chk("s4_start_once", start_cnt - base, 1);
        chk("s4_key", last_key, 4'd3);
        tick(200);
        chk("s4_no_second_start", start_cnt - base, 1);
        chk("s4_locks_held", {a_lock, b_lock}, 2'b11);
        a_btn = 3'b000;
        tick(40);
        chk("s4_partial_release_hold", {a_lock, b_lock}, 2'b11);
        b_btn = 3'b000;
        tick(10);
        chk("s4_release_too_short", {a_lock, b_lock}, 2'b11);
        tick(20);
        chk("s4_release_done", {a_lock, b_lock}, 2'b00);
        chk("s4_start_total", start_cnt - base, 1);

        // Match over while A is locked in COLLECT
        base = start_cnt;
        a_btn = S;
        tick(25);
        chk("s5_a_locked", {a_lock, b_lock}, 2'b10);
        player = 2'b10;
        tick(1);
        chk("s5_abort", {a_lock, b_lock}, 2'b00);
        b_btn = R;
        tick(30);
        chk("s5_no_lock_match_over", {a_lock, b_lock}, 2'b00);
        a_btn = 3'b000; b_btn = 3'b000;
        tick(10);
        player = 2'b00;
        tick(5);
        chk("s5_no_start", start_cnt - base, 0);

        // Reset pulsed in RELEASE
        base = start_cnt;
        a_btn = R; b_btn = R;
        tick(30);
        chk("s6_round_start", start_cnt - base, 1);
        chk("s6_round_key", last_key, 4'd0);
        chk("s6_in_release", {a_lock, b_lock}, 2'b11);
        #2 rst = 1'b0;
        #1;
        chk("s6_rst_rel_locks", {a_lock, b_lock}, 2'b00);
        chk("s6_rst_rel_key", key, 4'hF);
        chk("s6_rst_rel_start", start, 1'b0);
        a_btn = 3'b000; b_btn = 3'b000;
        tick(3);
        rst = 1'b1;
        tick(40);
        chk("s6_no_spurious_1", start_cnt - base, 1);
        chk("s6_locks_idle_1", {a_lock, b_lock}, 2'b00);

        // Reset pulsed in COLLECT
        a_btn = P;
        tick(25);
        chk("s6_collect_lock", {a_lock, b_lock}, 2'b10);
        #2 rst = 1'b0;
        #1;
        chk("s6_rst_col_locks", {a_lock, b_lock}, 2'b00);
        chk("s6_rst_col_key", key, 4'hF);
        a_btn = 3'b000;
        tick(3);
        rst = 1'b1;
        b_btn = S;
        tick(40);
        chk("s6_no_spurious_2", start_cnt - base, 1);
        chk("s6_b_only_after_rst", {a_lock, b_lock}, 2'b01);
        b_btn = 3'b000;
        tick(120);
        chk("s6_timeout_after_rst", {a_lock, b_lock}, 2'b00);

        // Every key code
        for (int i = 0; i < 9; i++) begin
            base = start_cnt;
            a_btn = a_tab[i]; b_btn = b_tab[i];
            tick(25);
            chk($sformatf("tab%0d_start", i), start_cnt - base, 1);
            chk($sformatf("tab%0d_key", i), last_key, k_tab[i]);
            a_btn = 3'b000; b_btn = 3'b000;
            tick(25);
            chk($sformatf("tab%0d_cleared", i), {a_lock, b_lock}, 2'b00);
        end

        chk("key_idle_outside_issue", key_bad, 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
